// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator: 4-phase sub-pixel sequencer, pixel/line counters,
// and a capture/output pipeline that re-aligns pixel_generator's color with registered syncs.
module vga_controller #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] color,
   output logic [9:0] pixel_counter,
   output logic [9:0] line_counter,
   output logic [1:0] pixel_state,
   output logic [7:0] vga_color,
   output logic       hsync,
   output logic       vsync,
   output logic       visible,
   output logic       frame_tick
);

   localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   typedef enum logic [1:0] {
      TEXT_FETCH  = 2'd0,
      GLYPH_FETCH = 2'd1,
      WAIT        = 2'd2,
      DRAW        = 2'd3
   } phase_t;

   phase_t     state;
   phase_t     state_next;
   logic [9:0] px_next;
   logic [9:0] ln_next;
   logic       frame_end;
   logic [9:0] cap_px;
   logic [9:0] cap_ln;
   logic       cap_valid;
   logic       vis_term;
   logic       hs_term;
   logic       vs_term;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= TEXT_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = TEXT_FETCH;
      if (enable) begin
         case (state)
            TEXT_FETCH:  state_next = GLYPH_FETCH;
            GLYPH_FETCH: state_next = WAIT;
            WAIT:        state_next = DRAW;
            DRAW:        state_next = TEXT_FETCH;
            default:     state_next = TEXT_FETCH;
         endcase
      end
   end

   assign pixel_state = state;

   always_comb begin
      px_next   = pixel_counter;
      ln_next   = line_counter;
      frame_end = 1'b0;
      if (!enable) begin
         px_next = '0;
         ln_next = '0;
      end else if (state == DRAW) begin
         if (pixel_counter == H_LAST) begin
            px_next = '0;
            if (line_counter == V_LAST) begin
               ln_next   = '0;
               frame_end = 1'b1;
            end else begin
               ln_next = line_counter + 10'd1;
            end
         end else begin
            px_next = pixel_counter + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_counter <= '0;
         line_counter  <= '0;
      end else begin
         pixel_counter <= px_next;
         line_counter  <= ln_next;
      end
   end

   // cap_valid keeps the output stage at reset values until a real capture exists,
   // so the first TEXT_FETCH edge after (re)start does not emit stale (0,0) data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_px    <= '0;
         cap_ln    <= '0;
         cap_valid <= 1'b0;
      end else if (!enable) begin
         cap_px    <= '0;
         cap_ln    <= '0;
         cap_valid <= 1'b0;
      end else if (state == DRAW) begin
         cap_px    <= pixel_counter;
         cap_ln    <= line_counter;
         cap_valid <= 1'b1;
      end
   end

   always_comb begin
      vis_term = (cap_px < H_VIS) && (cap_ln < V_VIS);
      hs_term  = !((cap_px >= HS_FIRST) && (cap_px <= HS_LAST));
      vs_term  = !((cap_ln >= VS_FIRST) && (cap_ln <= VS_LAST));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_color  <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         visible    <= 1'b0;
         frame_tick <= 1'b0;
      end else if (!enable) begin
         vga_color  <= '0;
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         visible    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (state == TEXT_FETCH && cap_valid) begin
            visible   <= vis_term;
            vga_color <= vis_term ? color : '0;
            hsync     <= hs_term;
            vsync     <= vs_term;
         end
      end
   end

endmodule

// File: doc/vga_controller.md
# vga_controller

Generates 640x480@60 Hz VGA timing from a 100 MHz clock (4 clocks per 25 MHz pixel) and drives the `pixel_counter`, `line_counter` and `pixel_state` inputs of `pixel_generator`. It also consumes the 8-bit `color` that `pixel_generator` produces. The block re-aligns that color with registered, delay-matched hsync/vsync and blanks it outside the visible area before it reaches the DAC pins.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  100 MHz system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high = run; low = synchronous clear to reset state.
- `color`  in  8  RRRGGGBB from `pixel_generator`.
- `pixel_counter`  out  10  current pixel 0..799.
- `line_counter`  out  10  current line 0..524.
- `pixel_state`  out  2  sub-pixel phase: 0 TEXT_FETCH, 1 GLYPH_FETCH, 2 WAIT, 3 DRAW.
- `vga_color`  out  8  blanked, registered color to the DAC.
- `hsync`  out  1  active-low horizontal sync, registered.
- `vsync`  out  1  active-low vertical sync, registered.
- `visible`  out  1  high while `vga_color` carries a visible pixel (aligned with it).
- `frame_tick`  out  1  one-clock pulse at the start of each new frame.

## Operation
- **Reset values** (`reset`=0, asynchronous): counters and `pixel_state` = 0; `hsync` = 1; `vsync` = 1; `vga_color` = 0; `visible` = 0; `frame_tick` = 0; internal capture registers = 0.
- **`enable`=0:** applies the same values synchronously, every clock, for as long as it is low.
- **Counter chain (when enabled):**
  - `pixel_state` increments every clock and wraps 3->0.
  - On the 3->0 wrap, `pixel_counter` increments.
  - `pixel_counter` wraps at H_TOTAL-1 (799)->0, and `line_counter` increments on that wrap.
  - `line_counter` wraps at V_TOTAL-1 (524)->0.
  - H_TOTAL and V_TOTAL are the sums of the four H and four V parameters.
- **Capture stage:** on every edge where `pixel_state`==3, latch `pixel_counter`/`line_counter` into `cap_px`/`cap_ln`.
- **Output stage:** on every edge where `pixel_state`==0, `color` holds `pixel_generator`'s result for (`cap_px`,`cap_ln`). Register:
  - `visible` <= (`cap_px` < H_VISIBLE) && (`cap_ln` < V_VISIBLE)
  - `vga_color` <= visible-term ? `color` : 0
  - `hsync` <= ~(`cap_px` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for 656..751
  - `vsync` <= ~(`cap_ln` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for 490..491
- **Output stability:** outputs change only on `pixel_state`==0 edges and are held for 4 clocks.
- **`frame_tick`:** registered; high for exactly the one cycle after the counters wrap from (line 524, pixel 799, state 3) to (0,0,0).
- **Wrap boundaries:** the final pixel (799, 524) is output normally after the wrap, because capture values carry across it.
- **Comparisons:** all arithmetic uses 10-bit unsigned values; range compares are inclusive as written.

## Timing
- Pixel period: 4 clocks. Line: 3200 clocks. Frame: 1,680,000 clocks.
- **Output latency:** pixel X has `pixel_state`==3 in cycle t. Its `vga_color`, `hsync`, `vsync` and `visible` are valid in cycles t+2..t+5.
- **After reset release or `enable` rising:**
  - Counters start advancing on the first enabled edge.
  - Outputs stay at reset values until the first `pixel_state`==0 edge that follows a capture. That edge is clock 5 after `enable` goes high: 4 increments reach state 0 again after a capture at state 3.
- **Mid-frame `reset` or `enable` drop:** everything returns to reset values (asynchronously for `reset`, on the next edge for `enable`). There is no partial-frame recovery, and no `frame_tick` is emitted for the restart.
- **Simultaneous events:** `reset` dominates `enable`. `enable`=0 dominates all counter and output updates.

## Test plan
- **Reset:** assert `reset`=0 mid-line while at pixel 300, line 100 -> counters and `pixel_state` 0, `hsync`=`vsync`=1, `vga_color`=0 immediately, without waiting for a clock.
- **Horizontal timing:** run one line with `color`=8'hFF ->
  - `hsync` low for exactly 384 clocks, starting 2 clocks after `pixel_state`==3 at pixel 656;
  - `vga_color`=FF for exactly 2560 clocks per visible line, and 0 elsewhere.
- **Vertical timing and frame tick:** run a full frame ->
  - `vsync` low for exactly 6400 clocks covering lines 490-491;
  - `frame_tick` pulses once every 1,680,000 clocks, each pulse 1 clock wide.
- **Color alignment:** drive `color` = `pixel_counter`[7:0] registered at DRAW (mimicking `pixel_generator`) -> `vga_color` at pixel X equals X[7:0] for X < 640, and is 0 at X = 640..799.
- **Enable drop:** drop `enable` for 10 clocks at line 200 -> outputs forced to reset values; after re-enable, counters restart at (0,0,0) and the first valid output appears 5 clocks later.
- **Wrap:** observe the transition across (799,524)->(0,0) -> `line_counter` returns to 0, the last pixel's blanked output is still emitted, and there is no glitch on `hsync` or `vsync`.
